// File: rtl/conv1d_stream_par.sv
// conv1d_stream_par: streaming valid-mode 1-D convolution with P saturating MAC lanes.
// Define CONV_RELU_EN to clamp negative results to zero before output buffering.
module conv1d_stream_par #(
    parameter int T = 16,
    parameter int N = 32,
    parameter int M = 4,
    parameter int P = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [T-1:0] f_data,
    input  logic         f_valid,
    output logic         f_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready
);
    localparam int K   = N - M + 1;
    localparam int G   = (K + P - 1) / P;
    localparam int XW  = $clog2(N + 1);
    localparam int FW  = $clog2(M + 1);
    localparam int XIW = (N > 1) ? $clog2(N) : 1;
    localparam int FIW = (M > 1) ? $clog2(M) : 1;
    localparam int GW  = $clog2(G + 1);
    localparam int CW  = $clog2(M + 4);
    localparam int LW  = $clog2(P + 1);
    localparam int AW  = $clog2(G * P + M + 4);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;
    typedef logic signed [T-1:0] word_t;

    localparam word_t W_MAX = {1'b0, {(T-1){1'b1}}};
    localparam word_t W_MIN = {1'b1, {(T-1){1'b0}}};

    function automatic word_t sat_mul(input word_t a, input word_t b);
        logic signed [2*T-1:0] p;
        p = (2*T)'(a) * (2*T)'(b);
        if (p[2*T-1:T-1] == '0 || p[2*T-1:T-1] == '1) return p[T-1:0];
        return p[2*T-1] ? W_MIN : W_MAX;
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b);
        logic signed [T:0] s;
        s = (T+1)'(a) + (T+1)'(b);
        if (s[T] == s[T-1]) return s[T-1:0];
        return s[T] ? W_MIN : W_MAX;
    endfunction

    function automatic word_t relu(input word_t v);
`ifdef CONV_RELU_EN
        return v[T-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    state_t        state_q, state_d;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [FW-1:0] f_cnt_q, f_cnt_d;
    logic [GW-1:0] g_q, g_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          rd_v_q, rd_v_d;
    logic          prod_v_q, prod_v_d;
    logic          x_ready_q, x_ready_d;
    logic          f_ready_q, f_ready_d;
    logic          y_valid_q, y_valid_d;
    word_t         f_rd_q, f_rd_d;
    word_t         x_rd_q [P];
    word_t         x_rd_d [P];
    word_t         prod_q [P];
    word_t         prod_d [P];
    word_t         acc_q  [P];
    word_t         acc_d  [P];
    word_t         res_q  [P];
    word_t         res_d  [P];
    word_t         x_mem  [P][N];
    word_t         f_mem  [M];
    logic          x_fire, f_fire, y_fire;
    logic          lane_last, grp_last;

    assign x_ready = x_ready_q;
    assign f_ready = f_ready_q;
    assign y_valid = y_valid_q;
    assign y_data  = res_q[0];

    always_comb begin
        x_fire    = x_valid && x_ready_q;
        f_fire    = f_valid && f_ready_q;
        y_fire    = y_valid_q && y_ready;
        lane_last = (lane_q == LW'(P - 1)) ||
                    (base_q + AW'(lane_q) == AW'(K - 1));
        grp_last  = (g_q == GW'(G - 1));
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        f_cnt_d   = f_cnt_q;
        g_d       = g_q;
        base_d    = base_q;
        cyc_d     = cyc_q;
        lane_d    = lane_q;
        y_valid_d = y_valid_q;
        res_d     = res_q;
        acc_d     = acc_q;
        rd_v_d    = (state_q == S_COMPUTE) && (cyc_q < CW'(M));
        prod_v_d  = rd_v_q;
        f_rd_d    = (cyc_q < CW'(M)) ? f_mem[cyc_q[FIW-1:0]] : '0;
        // Each lane reads its own copy of x at gP+j+k; out-of-frame lanes read 0.
        for (int j = 0; j < P; j++) begin
            logic [AW-1:0] addr;
            addr      = base_q + AW'(j) + AW'(cyc_q);
            x_rd_d[j] = (addr < AW'(N)) ? x_mem[j][addr[XIW-1:0]] : '0;
            prod_d[j] = sat_mul(x_rd_q[j], f_rd_q);
            if (prod_v_q) acc_d[j] = sat_add(acc_q[j], prod_q[j]);
        end
        unique case (state_q)
            S_LOAD: begin
                if (x_fire) x_cnt_d = x_cnt_q + 1'b1;
                if (f_fire) f_cnt_d = f_cnt_q + 1'b1;
                if (x_cnt_d == XW'(N) && f_cnt_d == FW'(M)) begin
                    state_d = S_COMPUTE;
                    x_cnt_d = '0;
                    f_cnt_d = '0;
                    g_d     = '0;
                    base_d  = '0;
                    cyc_d   = '0;
                    for (int j = 0; j < P; j++) acc_d[j] = '0;
                end
            end
            S_COMPUTE: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CW'(M + 2)) begin
                    state_d   = S_DRAIN;
                    lane_d    = '0;
                    y_valid_d = 1'b1;
                    for (int j = 0; j < P; j++) res_d[j] = relu(acc_q[j]);
                end
            end
            S_DRAIN: begin
                if (y_fire) begin
                    if (!lane_last) begin
                        lane_d = lane_q + 1'b1;
                        for (int j = 0; j < P - 1; j++) res_d[j] = res_q[j+1];
                    end else begin
                        y_valid_d = 1'b0;
                        if (grp_last) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_COMPUTE;
                            g_d     = g_q + 1'b1;
                            base_d  = base_q + AW'(P);
                            cyc_d   = '0;
                            for (int j = 0; j < P; j++) acc_d[j] = '0;
                        end
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
        x_ready_d = (state_d == S_LOAD) && (x_cnt_d != XW'(N));
        f_ready_d = (state_d == S_LOAD) && (f_cnt_d != FW'(M));
    end

    always_ff @(posedge clk) begin
        if (x_fire)
            for (int j = 0; j < P; j++) x_mem[j][x_cnt_q[XIW-1:0]] <= x_data;
        if (f_fire) f_mem[f_cnt_q[FIW-1:0]] <= f_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            x_cnt_q   <= '0;
            f_cnt_q   <= '0;
            g_q       <= '0;
            base_q    <= '0;
            cyc_q     <= '0;
            lane_q    <= '0;
            rd_v_q    <= 1'b0;
            prod_v_q  <= 1'b0;
            x_ready_q <= 1'b0;
            f_ready_q <= 1'b0;
            y_valid_q <= 1'b0;
            f_rd_q    <= '0;
            for (int j = 0; j < P; j++) begin
                x_rd_q[j] <= '0;
                prod_q[j] <= '0;
                acc_q[j]  <= '0;
                res_q[j]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            f_cnt_q   <= f_cnt_d;
            g_q       <= g_d;
            base_q    <= base_d;
            cyc_q     <= cyc_d;
            lane_q    <= lane_d;
            rd_v_q    <= rd_v_d;
            prod_v_q  <= prod_v_d;
            x_ready_q <= x_ready_d;
            f_ready_q <= f_ready_d;
            y_valid_q <= y_valid_d;
            f_rd_q    <= f_rd_d;
            x_rd_q    <= x_rd_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
        end
    end
endmodule

// File: tb/tb_conv1d_stream_par.sv
// tb_conv1d_stream_par: scoreboard bench for N=8, M=3 with P=2 and P=4 instances.
// Expected outputs come from a behavioural saturating convolution model.
`timescale 1ns/1ps
module tb_conv1d_stream_par;
    localparam int T = 16;
    localparam int N = 8;
    localparam int M = 3;
    localparam int K = N - M + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [T-1:0] x_data = '0;
    logic [T-1:0] f_data = '0;
    logic         x_valid = 1'b0;
    logic         f_valid = 1'b0;
    logic         y_ready = 1'b0;
    logic         x_ready_a, f_ready_a, y_valid_a;
    logic         x_ready_b, f_ready_b, y_valid_b;
    logic [T-1:0] y_data_a, y_data_b;

    int n_vec = 0;
    int n_err = 0;
    int rdy_pct = 100;
    int qa[$];
    int qb[$];
    bit xr_chk_a = 1'b0;
    bit xr_chk_b = 1'b0;
    bit stall_a = 1'b0;
    logic [T-1:0] prev_a = '0;

    int ramp[N] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int xmax[N] = '{default: 32767};
    int xmin[N] = '{default: -32768};
    int f111[M] = '{1, 1, 1};
    int fneg[M] = '{-1, 0, 0};
    int f222[M] = '{2, 2, 2};
    int f123[M] = '{1, 2, 3};

    always #5 clk = ~clk;

    conv1d_stream_par #(.T(T), .N(N), .M(M), .P(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_a),
        .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_a),
        .y_data(y_data_a), .y_valid(y_valid_a), .y_ready(y_ready)
    );

    conv1d_stream_par #(.T(T), .N(N), .M(M), .P(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_b),
        .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_b),
        .y_data(y_data_b), .y_valid(y_valid_b), .y_ready(y_ready)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input longint v);
        longint hi = (longint'(1) <<< (T - 1)) - 1;
        longint lo = -(longint'(1) <<< (T - 1));
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    function automatic int model(input int xs[N], input int fs[M], input int i);
        int acc = 0;
        for (int k = 0; k < M; k++)
            acc = sat(longint'(acc) + sat(longint'(xs[i+k]) * fs[k]));
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            y_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    always @(negedge clk) begin
        if (xr_chk_a) begin
            chk("xrdy_after_frame_a", int'(x_ready_a), 1);
            xr_chk_a = 1'b0;
        end
        if (stall_a) begin
            chk("hold_valid", int'(y_valid_a), 1);
            chk("hold_data", int'(y_data_a), int'(prev_a));
        end
        stall_a = !reset && y_valid_a && !y_ready;
        prev_a = y_data_a;
        if (!reset && y_valid_a && y_ready) begin
            chk("pending_a", int'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                chk("y_a", int'($signed(y_data_a)), qa.pop_front());
                if (qa.size() == 0) xr_chk_a = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (xr_chk_b) begin
            chk("xrdy_after_frame_b", int'(x_ready_b), 1);
            xr_chk_b = 1'b0;
        end
        if (!reset && y_valid_b && y_ready) begin
            chk("pending_b", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                chk("y_b", int'($signed(y_data_b)), qb.pop_front());
                if (qb.size() == 0) xr_chk_b = 1'b1;
            end
        end
    end

    task automatic run_frame(input int xs[N], input int fs[M],
                             input bit gaps, input bit lat);
        int xi = 0;
        int fi = 0;
        int nl = 0;
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (x_ready_a && x_ready_b && f_ready_a && f_ready_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("ready_wait", int'(x_ready_a && x_ready_b), 1);
            return;
        end
        for (int i = 0; i < K; i++) begin
            qa.push_back(model(xs, fs, i));
            qb.push_back(model(xs, fs, i));
        end
        for (int c = 0; c < 400 && (xi < N || fi < M); c++) begin
            if (c > 0) @(negedge clk);
            x_valid = (xi < N) && (!gaps || $urandom_range(0, 2) != 0);
            f_valid = (fi < M) && (!gaps || $urandom_range(0, 2) != 0);
            x_data  = T'(xs[(xi < N) ? xi : N - 1]);
            f_data  = T'(fs[(fi < M) ? fi : M - 1]);
            if (x_valid && x_ready_a) xi++;
            if (f_valid && f_ready_a) fi++;
        end
        if (lat) begin
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    x_valid = 1'b0;
                    f_valid = 1'b0;
                end
                if (y_valid_a) begin
                    nl = c;
                    break;
                end
            end
            chk("first_y_latency", nl, M + 4);
        end else begin
            @(negedge clk);
            x_valid = 1'b0;
            f_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0) break;
        end
        chk("drain", qa.size() + qb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x_ready", int'(x_ready_a), 0);
        chk("rst_f_ready", int'(f_ready_a), 0);
        chk("rst_y_valid", int'(y_valid_a), 0);
        chk("rst_y_data", int'(y_data_a), 0);
        chk("rst_y_valid_b", int'(y_valid_b), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("x_ready_rise", int'(x_ready_a), 1);
        chk("f_ready_rise", int'(f_ready_a), 1);

        run_frame(ramp, f111, 1'b0, 1'b1);
        wait_drain();
        run_frame(ramp, fneg, 1'b0, 1'b0);
        wait_drain();
        run_frame(xmax, f222, 1'b0, 1'b0);
        wait_drain();
        run_frame(xmin, f222, 1'b0, 1'b0);
        wait_drain();

        rdy_pct = 30;
        run_frame(ramp, f123, 1'b1, 1'b1);
        wait_drain();
        rdy_pct = 100;

        run_frame(ramp, f123, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_x_ready", int'(x_ready_a), 0);
        chk("abort_f_ready", int'(f_ready_a), 0);
        chk("abort_y_valid", int'(y_valid_a), 0);
        chk("abort_y_data", int'(y_data_a), 0);
        chk("abort_y_valid_b", int'(y_valid_b), 0);
        qa.delete();
        qb.delete();
        reset = 1'b0;

        run_frame(ramp, f111, 1'b0, 1'b1);
        wait_drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
